// File: rtl/demux_pkg.sv
// Shared types and constants for the registered 1-to-N stream demultiplexer.
package demux_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_SCAN = 1'b1;

endpackage

// File: rtl/demux1_n_stream_if.sv
// Stream bus of the demultiplexer: one producer side, N consumer channels.
interface demux1_n_stream_if #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 8
);
    localparam int unsigned SW = $clog2(N);

    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_data;
    logic [SW-1:0]     in_sel;
    logic [N-1:0]      out_valid;
    logic [N-1:0]      out_ready;
    logic [N*W-1:0]    out_data;

    // Environment side: producer plus all consumers
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Demultiplexer side
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/demux_scan_ptr.sv
// Wrap-at-N channel pointer for scan mode; advances by one when inc is high.
module demux_scan_ptr #(
    parameter  int unsigned N  = 16,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [SW-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == SW'(N - 1)) ? '0 : ptr + SW'(1);
        end
    end

endmodule

// File: rtl/demux1_n_stream.sv
// Registered 1-to-N stream demultiplexer with active-low enable and valid/ready per channel.
// Optional round-robin scan mode is built when DEMUX_SCAN_EN is defined.
module demux1_n_stream
    import demux_pkg::*;
#(
    parameter  int unsigned N  = 16,
    parameter  int unsigned W  = 8,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_n,
    input  logic               mode,
    demux1_n_stream_if.slave   bus,
    output logic [SW-1:0]      ptr,
    output logic               err
);

    localparam bit            POW2 = (N == (1 << SW));
    localparam logic [SW:0]   NLIM = (SW + 1)'(N);

    state_t            state_q, state_d;
    logic [SW-1:0]     hold_q, hold_d;
    logic [N-1:0]      valid_q, valid_d;
    logic [N*W-1:0]    data_q, data_d;
    logic              err_q, err_d;

    logic              rdy_sel_c;
    logic              in_ready_c;
    logic              xfer_c;
    logic              drain_c;
    logic              in_range_c;
    logic              scan_c;
    logic              mode_eff_c;
    logic [SW-1:0]     dest_c;
    logic [SW-1:0]     ptr_c;

`ifdef DEMUX_SCAN_EN
    demux_scan_ptr #(.N(N)) u_scan_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (xfer_c && scan_c),
        .ptr   (ptr_c)
    );
    assign mode_eff_c = mode;
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign ptr_c       = '0;
    assign mode_eff_c  = MODE_ADDR;
`endif

    assign scan_c = (mode_eff_c == MODE_SCAN);
    assign dest_c = scan_c ? ptr_c : bus.in_sel;

    // Out-of-range destinations exist only for non power-of-two channel counts
    generate
        if (POW2) begin : g_range_pow2
            assign in_range_c = 1'b1;
        end else begin : g_range_cmp
            assign in_range_c = ({1'b0, dest_c} < NLIM);
        end
    endgenerate

    // Ready of the consumer that owns the held word
    always_comb begin
        rdy_sel_c = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (hold_q == SW'(k)) rdy_sel_c = bus.out_ready[k];
        end
    end

    assign in_ready_c = rst_n && !en_n && ((state_q == ST_EMPTY) || rdy_sel_c);
    assign xfer_c     = bus.in_valid && in_ready_c;
    assign drain_c    = (state_q == ST_FULL) && rdy_sel_c;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = 1'b0;

        if (drain_c) begin
            state_d = ST_EMPTY;
            valid_d = '0;
            data_d  = '0;
        end

        if (xfer_c) begin
            if (in_range_c) begin
                state_d = ST_FULL;
                hold_d  = dest_c;
                valid_d = '0;
                data_d  = '0;
                for (int k = 0; k < N; k++) begin
                    if (dest_c == SW'(k)) begin
                        valid_d[k]       = 1'b1;
                        data_d[k*W +: W] = bus.in_data;
                    end
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            hold_q  <= '0;
            valid_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign ptr           = ptr_c;
    assign err           = err_q;

endmodule

// File: tb/tb_demux1_n_stream.sv
// Self-checking bench for demux1_n_stream: N=16 instance against a reference model, N=12 instance for range errors.
module tb_demux1_n_stream;

    localparam int unsigned N  = 16;
    localparam int unsigned N2 = 12;
    localparam int unsigned W  = 8;
`ifdef DEMUX_SCAN_EN
    localparam bit SCAN = 1'b1;
`else
    localparam bit SCAN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_n, mode, en2_n, mode2;
    logic [3:0] ptr, ptr2;
    logic       err, err2;

    always #5 clk = ~clk;

    demux1_n_stream_if #(.N(N),  .W(W)) b16 ();
    demux1_n_stream_if #(.N(N2), .W(W)) b12 ();

    demux1_n_stream #(.N(N), .W(W)) u16 (
        .clk(clk), .rst_n(rst_n), .en_n(en_n), .mode(mode),
        .bus(b16.slave), .ptr(ptr), .err(err)
    );

    demux1_n_stream #(.N(N2), .W(W)) u12 (
        .clk(clk), .rst_n(rst_n), .en_n(en2_n), .mode(mode2),
        .bus(b12.slave), .ptr(ptr2), .err(err2)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: at most one held word, plus a scan pointer
    bit         m_have;
    int         m_ch;
    logic [7:0] m_data;
    int         m_ptr;

    typedef struct {
        logic        en_n;
        logic        mode;
        logic        vld;
        logic [3:0]  sel;
        logic [7:0]  data;
        logic [15:0] ordy;
        logic        exp_rdy;
        logic [15:0] exp_valid;
        logic [7:0]  exp_word;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] build(input logic [15:0] v, input logic [7:0] word);
        logic [127:0] d;
        d = '0;
        for (int k = 0; k < 16; k++) if (v[k]) d[k*8 +: 8] = word;
        return d;
    endfunction

    // One clock of the N=16 instance, checked against the model
    task automatic cyc16(input logic e, input logic md, input logic v, input logic [3:0] s,
                         input logic [7:0] d, input logic [15:0] r, output logic rs);
        bit         rdy, xfer, drain, e_err;
        int         dest;
        logic [15:0] ev;
        en_n = e; mode = md;
        b16.in_valid = v; b16.in_sel = s; b16.in_data = d; b16.out_ready = r;
        #1;
        rdy = !e && (!m_have || r[m_ch]);
        rs  = b16.in_ready;
        chk("in_ready", 128'(b16.in_ready), 128'(rdy));
        @(posedge clk);
        xfer  = v && rdy;
        drain = m_have && r[m_ch];
        dest  = (SCAN && md) ? m_ptr : int'(s);
        e_err = 1'b0;
        if (drain) m_have = 1'b0;
        if (xfer) begin
            if (dest < int'(N)) begin
                m_have = 1'b1; m_ch = dest; m_data = d;
            end else begin
                e_err = 1'b1;
            end
            if (SCAN && md) m_ptr = (m_ptr + 1) % int'(N);
        end
        #1;
        ev = m_have ? (16'h1 << m_ch) : 16'h0;
        chk("out_valid", 128'(b16.out_valid), 128'(ev));
        chk("out_data", 128'(b16.out_data), build(ev, m_data));
        chk("ptr", 128'(ptr), 128'(m_ptr));
        chk("err", 128'(err), 128'(e_err));
    endtask

    initial begin
        logic        rs;
        logic [3:0]  s;
        int          ch;

        en_n = 1'b0; mode = 1'b0; en2_n = 1'b0; mode2 = 1'b0;
        b16.in_valid = 1'b1; b16.in_sel = '0; b16.in_data = 8'hFF; b16.out_ready = '1;
        b12.in_valid = 1'b0; b12.in_sel = '0; b12.in_data = '0;    b12.out_ready = '1;
        m_have = 1'b0; m_ch = 0; m_data = '0; m_ptr = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(b16.in_ready), 128'(0));
        chk("rst_out_valid", 128'(b16.out_valid), 128'(0));
        chk("rst_out_data", 128'(b16.out_data), 128'(0));
        chk("rst_ptr", 128'(ptr), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        b16.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        tbl[0]  = '{1'b0, 1'b0, 1'b1, 4'd3,  8'hA5, 16'hFFFF, 1'b1, 16'h0008, 8'hA5};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 4'd12, 8'h5A, 16'hFFFF, 1'b1, 16'h1000, 8'h5A};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'd0,  8'h00, 16'hFFFF, 1'b1, 16'h0000, 8'h00};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 4'd5,  8'h33, 16'hFFFF, 1'b1, 16'h0020, 8'h33};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 4'd7,  8'h44, 16'hFFDF, 1'b0, 16'h0020, 8'h33};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 4'd7,  8'h44, 16'hFFDF, 1'b0, 16'h0020, 8'h33};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 4'd7,  8'h44, 16'hFFFF, 1'b1, 16'h0080, 8'h44};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 4'd2,  8'h55, 16'hFF7F, 1'b0, 16'h0080, 8'h44};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 4'd2,  8'h55, 16'hFFFF, 1'b0, 16'h0000, 8'h00};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 4'd2,  8'h55, 16'hFFFF, 1'b0, 16'h0000, 8'h00};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 4'd15, 8'h99, 16'hFFFF, 1'b1, 16'h8000, 8'h99};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 4'd0,  8'h00, 16'h0000, 1'b0, 16'h8000, 8'h99};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 4'd0,  8'h11, 16'hFFFF, 1'b1, 16'h0001, 8'h11};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 4'd0,  8'h00, 16'hFFFF, 1'b1, 16'h0000, 8'h00};

        foreach (tbl[i]) begin
            cyc16(tbl[i].en_n, tbl[i].mode, tbl[i].vld, tbl[i].sel, tbl[i].data, tbl[i].ordy, rs);
            chk($sformatf("tbl%0d_ready", i), 128'(rs), 128'(tbl[i].exp_rdy));
            chk($sformatf("tbl%0d_valid", i), 128'(b16.out_valid), 128'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_data", i), 128'(b16.out_data), build(tbl[i].exp_valid, tbl[i].exp_word));
        end

        // Scan mode: 18 consecutive words; without scan support mode is ignored
        for (int i = 0; i < 18; i++) begin
            s  = 4'($urandom);
            ch = SCAN ? (i % 16) : int'(s);
            cyc16(1'b0, 1'b1, 1'b1, s, 8'(i + 1), 16'hFFFF, rs);
            chk("scan_valid", 128'(b16.out_valid), 128'(16'h1 << ch));
            chk("scan_data", 128'(b16.out_data), build(16'h1 << ch, 8'(i + 1)));
        end
        chk("scan_ptr_end", 128'(ptr), SCAN ? 128'(2) : 128'(0));
        cyc16(1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 16'hFFFF, rs);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc16(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0), 4'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF, rs);
        end

        // N=12: out-of-range destination is accepted, dropped and flagged
        @(posedge clk); #1;
        b12.in_valid = 1'b1; b12.in_sel = 4'd13; b12.in_data = 8'hAA;
        #1;
        chk("n12_oor_ready", 128'(b12.in_ready), 128'(1));
        @(posedge clk); #1;
        chk("n12_oor_err", 128'(err2), 128'(1));
        chk("n12_oor_valid", 128'(b12.out_valid), 128'(0));
        b12.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("n12_err_pulse", 128'(err2), 128'(0));
        b12.in_valid = 1'b1; b12.in_sel = 4'd11; b12.in_data = 8'h3C;
        @(posedge clk); #1;
        chk("n12_ch11_valid", 128'(b12.out_valid), 128'(12'h800));
        chk("n12_ch11_data", 128'(b12.out_data), 128'(8'h3C) << 88);
        b12.in_sel = 4'd14; b12.in_data = 8'h77;
        #1;
        chk("n12_oor_full_ready", 128'(b12.in_ready), 128'(1));
        @(posedge clk); #1;
        chk("n12_drain_err", 128'(err2), 128'(1));
        chk("n12_drain_valid", 128'(b12.out_valid), 128'(0));
        chk("n12_drain_data", 128'(b12.out_data), 128'(0));
        chk("n12_ptr", 128'(ptr2), 128'(0));
        b12.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("n12_err_clear", 128'(err2), 128'(0));

        // Reset while a word is held and stalled
        cyc16(1'b0, 1'b1, 1'b1, 4'd6, 8'h77, 16'hFFFF, rs);
        cyc16(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 16'h0000, rs);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 128'(b16.out_valid), 128'(0));
        chk("midrst_data", 128'(b16.out_data), 128'(0));
        chk("midrst_ptr", 128'(ptr), 128'(0));
        chk("midrst_ready", 128'(b16.in_ready), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        m_have = 1'b0; m_ptr = 0;
        @(posedge clk); #1;
        cyc16(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 16'hFFFF, rs);
        chk("postrst_valid", 128'(b16.out_valid), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux1_n_stream.md
# demux1_n_stream

Parametrised, registered 1-to-N stream demultiplexer: the next generation of the combinational 1-to-16 demux with active-low enable. It keeps the active-low enable. It adds:
- configurable channel count and data width,
- a valid/ready handshake on the input and on every output channel,
- a one-word output register,
- an optional round-robin scan mode.

It sits between a single producer and N consumer channels.

## Interface
- N, 16, number of output channels (≥2); SW = $clog2(N) is a derived localparam
- W, 8, data word width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en_n  input  1  active-low enable; 1 blocks new input words
- mode  input  1  0 = addressed (route by in_sel), 1 = scan (route by ptr)
- in_valid  input  1  input word present
- in_ready  output  1  block accepts input this cycle
- in_data  input  W  input word
- in_sel  input  SW  destination channel in addressed mode
- out_valid  output  N  one-hot; channel k holds a word
- out_ready  input  N  channel k consumer ready
- out_data  output  N*W  slice k = bits [k*W +: W]
- ptr  output  SW  current scan pointer
- err  output  1  one-cycle pulse: accepted word had in_sel ≥ N and was dropped

## Operation
- Two states:
  - ST_EMPTY: no word held.
  - ST_FULL: word held for channel hold_ch.
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - A drain occurs when ST_FULL && out_ready[hold_ch].
- in_ready = !en_n && (ST_EMPTY || out_ready[hold_ch]). Draining and accepting in the same cycle gives back-to-back throughput.
- Destination:
  - mode 0: in_sel.
  - mode 1: ptr. ptr advances on every input transfer in mode 1 and wraps from N-1 to 0.
- ptr holds its value in mode 0. A mode change takes effect on the next input transfer.
- Out-of-range destination (in_sel ≥ N, possible only when N is not a power of 2):
  - The word is accepted and discarded.
  - err pulses for one cycle.
  - State is unchanged. If the block was ST_FULL and the held word drained that cycle, it goes to ST_EMPTY.
- Transitions:
  - ST_EMPTY → ST_FULL on a valid in-range transfer.
  - ST_FULL → ST_FULL on drain plus new in-range transfer; hold_ch and data are replaced.
  - ST_FULL → ST_EMPTY on drain with no new in-range transfer.
- Outputs:
  - out_valid[k] = ST_FULL && hold_ch == k.
  - out_data slice hold_ch carries the word. All other slices are 0, matching the combinational demux.
- en_n = 1 blocks new input words only. A held word still drains normally.

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word/cycle while the destination consumer stays ready.
- Reset values (asynchronous, applied immediately):
  - state ST_EMPTY
  - out_valid 0
  - out_data 0
  - ptr 0
  - err 0
  - hold_ch 0
- in_ready is combinational. It is 0 during reset and whenever en_n = 1.
- Reset asserted mid-operation discards any held word; nothing is delivered after reset releases.
- out_valid and out_data stay stable while a channel is stalled (out_ready low).
- in_sel and mode are sampled only on an input transfer.

## Configuration
- DEMUX_SCAN_EN defined: scan mode is available as described above.
- DEMUX_SCAN_EN undefined:
  - mode is ignored and the block operates in addressed mode only.
  - ptr is tied to 0 and the scan counter is not synthesised.

## Structure
- Shared package demux_pkg holds:
  - state typedef with ST_EMPTY and ST_FULL
  - mode constants MODE_ADDR = 1'b0 and MODE_SCAN = 1'b1
- One sub-module, demux_scan_ptr: a wrap-at-N counter with increment enable. It is instantiated only under DEMUX_SCAN_EN.

## Test plan
- N=16, W=8, mode 0, all out_ready=1; send 0xA5 with sel 3, then 0x5A with sel 12:
  - cycle+1: out_valid = 0x0008 with slice 3 = 0xA5.
  - next cycle: out_valid = 0x1000 with slice 12 = 0x5A.
  - all other slices are 0.
- Backpressure:
  - Word for sel 5 while out_ready[5] = 0: in_ready drops to 0 and the word stays stable.
  - Raise out_ready[5] with the next word pending: the held word drains and the next word is accepted in the same cycle.
- Scan mode, N=16, 18 consecutive words: delivered to channels 0…15, then 0, 1. ptr reads 2 at the end.
- N=12, mode 0, sel 13: in_ready = 1, err pulses for one cycle, out_valid stays 0.
- Enable and reset:
  - en_n = 1 with in_valid = 1: in_ready = 0 and nothing is accepted, but a previously held word still drains.
  - rst_n pulsed low while ST_FULL: out_valid clears immediately and ptr = 0.
